beta_boot_ctrl: RTL and testbench

//   Hardware boot/run/readback controller for the unpipelined beta core.
//   - Streams an instruction image and a data image into imem/dmem while holding the core in reset.
//   - Releases the core and runs it until halt (PC stable) or timeout.
//   - Reads back a window of dmem words for on-chip checking.
//   - Replaces bench-side preload and fixed-delay sampling; the flow stays the same on FPGA.

---
 rtl/beta_boot_pkg.sv | 6 +
 rtl/beta_halt_detect.sv | 29 ++
 rtl/beta_boot_ctrl.sv | 110 +++++++++++
 tb/tb_beta_boot_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_boot_pkg.sv
// beta_boot_pkg: controller states and load-select encodings shared by the beta boot controller.
package beta_boot_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, READBACK, DONE} state_t;
  localparam logic LD_SEL_IMEM = 1'b0;
  localparam logic LD_SEL_DMEM = 1'b1;
endpackage

// File: rtl/beta_halt_detect.sv
// beta_halt_detect: flags halt once cpu_pc has matched its previous value HALT_STABLE cycles in a row.
module beta_halt_detect #(
  parameter int PC_W        = 32,
  parameter int HALT_STABLE = 4
) (
  input  logic            clk,
  input  logic            RESET_N,
  input  logic            clear,
  input  logic [PC_W-1:0] cpu_pc,
  output logic            halt
);
  localparam int CW = $clog2(HALT_STABLE);
  logic [PC_W-1:0] prev;
  logic [CW-1:0] cnt;
  logic seen, same;
  // the first sample after clear only primes prev; it is never compared
  assign same = seen && cpu_pc == prev;
  assign halt = same && cnt == CW'(HALT_STABLE - 1);
  always_ff @(posedge clk)
    if (!RESET_N || clear) begin
      seen <= 1'b0;
      prev <= '0;
      cnt  <= '0;
    end else begin
      seen <= 1'b1;
      prev <= cpu_pc;
      cnt  <= !same ? '0 : halt ? cnt : cnt + 1'b1;
    end
endmodule

// File: rtl/beta_boot_ctrl.sv
// beta_boot_ctrl: load/run/readback sequencer around the unpipelined beta core and its memories.
// Defining BETA_BOOT_CYCLE_CNT_EN adds the saturating run_cycles output.
module beta_boot_ctrl
  import beta_boot_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int INSTR_W     = 32,
  parameter int PC_W        = 32,
  parameter int IMEM_AW     = 8,
  parameter int DMEM_AW     = 4,
  parameter int HALT_STABLE = 4,
  parameter int TIMEOUT     = 1024,
  parameter int RB_BASE     = 0,
  parameter int RB_WORDS    = 2
) (
  input  logic               clk,
  input  logic               RESET_N,
  input  logic               start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic               ld_sel,
  input  logic               ld_last,
  input  logic [DATA_W-1:0]  ld_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               cpu_reset,
  input  logic [PC_W-1:0]    cpu_pc,
  output logic               rb_valid,
  output logic [DMEM_AW-1:0] rb_idx,
  output logic [DATA_W-1:0]  rb_data,
  output logic               done,
  output logic               timeout,
  output logic               ld_ovf
`ifdef BETA_BOOT_CYCLE_CNT_EN
  ,
  output logic [15:0]        run_cycles
`endif
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  // pointer MSB set means the memory is full: further words are dropped
  logic [IMEM_AW:0] iptr;
  logic [DMEM_AW:0] dptr, rb_cnt;
  logic [TW-1:0] run_cnt;
  logic [DMEM_AW-1:0] rb_addr;
  logic take, drop, expire, restart, halt;
  beta_halt_detect #(.PC_W(PC_W), .HALT_STABLE(HALT_STABLE)) u_halt (
    .clk(clk),
    .RESET_N(RESET_N),
    .clear(state != RUN),
    .cpu_pc(cpu_pc),
    .halt(halt)
  );
  always_ff @(posedge clk)
    if (!RESET_N) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt        = state;
    restart    = (state == IDLE || state == DONE) && start;
    ld_ready   = state == LOAD;
    cpu_reset  = state != RUN;
    done       = state == DONE;
    take       = ld_ready && ld_valid;
    imem_we    = take && ld_sel == LD_SEL_IMEM && !iptr[IMEM_AW];
    dmem_we    = take && ld_sel == LD_SEL_DMEM && !dptr[DMEM_AW];
    drop       = take && (ld_sel == LD_SEL_IMEM ? iptr[IMEM_AW] : dptr[DMEM_AW]);
    imem_addr  = imem_we ? iptr[IMEM_AW-1:0] : '0;
    imem_wdata = imem_we ? ld_data[INSTR_W-1:0] : '0;
    dmem_wdata = dmem_we ? ld_data : '0;
    rb_addr    = DMEM_AW'(RB_BASE) + rb_cnt[DMEM_AW-1:0];
    dmem_addr  = state == LOAD ? dptr[DMEM_AW-1:0] : state == READBACK ? rb_addr : '0;
    rb_valid   = state == READBACK && rb_cnt != '0;
    rb_idx     = rb_valid ? DMEM_AW'(rb_cnt - 1'b1) : '0;
    rb_data    = rb_valid ? dmem_rdata : '0;
    expire     = run_cnt == TW'(TIMEOUT - 1);
    case (state)
      IDLE, DONE: nxt = start ? LOAD : state;
      LOAD:       nxt = take && ld_last ? RUN : LOAD;
      RUN:        nxt = halt || expire ? READBACK : RUN;
      READBACK:   nxt = rb_cnt == (DMEM_AW + 1)'(RB_WORDS) ? DONE : READBACK;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!RESET_N || restart) begin
      iptr    <= '0;
      dptr    <= '0;
      rb_cnt  <= '0;
      run_cnt <= '0;
      timeout <= 1'b0;
      ld_ovf  <= 1'b0;
    end else begin
      if (imem_we) iptr <= iptr + 1'b1;
      if (dmem_we) dptr <= dptr + 1'b1;
      if (drop) ld_ovf <= 1'b1;
      if (state == RUN) run_cnt <= run_cnt + 1'b1;
      if (state == RUN && expire && !halt) timeout <= 1'b1;
      if (state == READBACK) rb_cnt <= rb_cnt + 1'b1;
    end
`ifdef BETA_BOOT_CYCLE_CNT_EN
  always_ff @(posedge clk)
    if (!RESET_N || restart) run_cycles <= '0;
    else if (state == RUN && run_cycles != 16'hFFFF) run_cycles <= run_cycles + 1'b1;
`endif
endmodule

// File: tb/tb_beta_boot_ctrl.sv
// tb_beta_boot_ctrl: directed boot/run/readback scenarios checked against a behavioural model every cycle.
module tb_beta_boot_ctrl;
  localparam int TO = 64;
  localparam int HS = 4;
  localparam int IDEP = 256;
  localparam int DDEP = 16;
  localparam int RB_BASE = 0;
  localparam int RB_WORDS = 2;
  logic clk = 0, RESET_N = 0, start = 0, ld_valid = 0, ld_sel = 0, ld_last = 0;
  logic [127:0] ld_data = '0, dmem_rdata = '0, b_rdata = '0;
  logic [31:0] cpu_pc = '0, b_pc = '0, stop_pc;
  logic ld_ready, imem_we, dmem_we, cpu_reset, rb_valid, done, timeout, ld_ovf;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [3:0] dmem_addr, rb_idx;
  logic [127:0] dmem_wdata, rb_data;
  logic b_ld_ready, b_imem_we, b_dmem_we, b_cpu_reset, b_rb_valid, b_done, b_timeout, b_ld_ovf;
  logic [7:0] b_imem_addr;
  logic [31:0] b_imem_wdata;
  logic [1:0] b_dmem_addr, b_rb_idx;
  logic [127:0] b_dmem_wdata, b_rb_data;
`ifdef BETA_BOOT_CYCLE_CNT_EN
  logic [15:0] run_cycles, b_run_cycles;
`endif
  logic [127:0] bmem [DDEP];
  logic [127:0] rb_seen [2];
  bit store_en;
  int checks = 0, errors = 0;
  int n_iw, n_dw, n_bw, n_run, n_rb, ia_bad, da_bad, ba_bad;

  always #5 clk = ~clk;

  beta_boot_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .RESET_N(RESET_N), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_sel(ld_sel), .ld_last(ld_last), .ld_data(ld_data), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .cpu_reset(cpu_reset), .cpu_pc(cpu_pc), .rb_valid(rb_valid),
    .rb_idx(rb_idx), .rb_data(rb_data), .done(done), .timeout(timeout), .ld_ovf(ld_ovf)
`ifdef BETA_BOOT_CYCLE_CNT_EN
    , .run_cycles(run_cycles)
`endif
  );

  beta_boot_ctrl #(.TIMEOUT(TO), .DMEM_AW(2)) u_small (
    .clk(clk), .RESET_N(RESET_N), .start(start), .ld_valid(ld_valid), .ld_ready(b_ld_ready),
    .ld_sel(ld_sel), .ld_last(ld_last), .ld_data(ld_data), .imem_we(b_imem_we), .imem_addr(b_imem_addr),
    .imem_wdata(b_imem_wdata), .dmem_we(b_dmem_we), .dmem_addr(b_dmem_addr), .dmem_wdata(b_dmem_wdata),
    .dmem_rdata(b_rdata), .cpu_reset(b_cpu_reset), .cpu_pc(b_pc), .rb_valid(b_rb_valid),
    .rb_idx(b_rb_idx), .rb_data(b_rb_data), .done(b_done), .timeout(b_timeout), .ld_ovf(b_ld_ovf)
`ifdef BETA_BOOT_CYCLE_CNT_EN
    , .run_cycles(b_run_cycles)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] iword(input int i);
    return {96'hDEAD_BEEF_0000_1111_2222_3333, 32'h1000_0000 + 32'(i)};
  endfunction

  function automatic logic [127:0] dword(input int i);
    return {32'hCAFE_0000 + 32'(i), 64'h0123_4567_89AB_CDEF, 32'(i)};
  endfunction

  // memories and a stand-in core: dmem read data lags the address by one cycle,
  // the core steps pc by 4 until stop_pc (its self-loop) and may store sum(1..10) to dmem[1]
  initial begin
    logic [3:0] a;
    bit rst;
    int s;
    s = 0;
    for (int k = 1; k <= 10; k++) s += k;
    forever begin
      @(negedge clk);
      a = dmem_addr;
      rst = cpu_reset;
      if (dmem_we) bmem[dmem_addr] = dmem_wdata;
      @(posedge clk);
      #1;
      dmem_rdata = bmem[a];
      if (rst) cpu_pc = '0;
      else if (cpu_pc != stop_pc) begin
        cpu_pc += 4;
        if (store_en && cpu_pc == stop_pc) bmem[1] = 128'(s);
      end
    end
  end

  // behavioural model: phase 0 idle, 1 load, 2 run, 3 readback, 4 done
  initial begin
    int ph, ip, dp, rc, ri;
    bit to, ovf, tk, iw, dw, rv, halted;
    logic [31:0] pcs [$];
    ph = -1;
    forever begin
      @(negedge clk);
      if (ph >= 0) begin
        tk = ph == 1 && ld_valid;
        iw = tk && !ld_sel && ip < IDEP;
        dw = tk && ld_sel && dp < DDEP;
        rv = ph == 3 && ri > 0;
        chk("cpu_reset", cpu_reset, ph != 2);
        chk("ld_ready", ld_ready, ph == 1);
        chk("imem_we", imem_we, iw);
        chk("dmem_we", dmem_we, dw);
        if (iw) begin
          chk("imem_addr", imem_addr, ip);
          chk("imem_wdata", imem_wdata, ld_data[31:0]);
        end
        if (dw) begin
          chk("dmem_addr", dmem_addr, dp);
          chk("dmem_wdata", dmem_wdata, ld_data);
        end
        if (ph == 3 && ri < RB_WORDS) chk("rb_addr", dmem_addr, (RB_BASE + ri) % DDEP);
        chk("rb_valid", rb_valid, rv);
        if (rv) begin
          chk("rb_idx", rb_idx, ri - 1);
          chk("rb_data", rb_data, bmem[(RB_BASE + ri - 1) % DDEP]);
        end
        chk("done", done, ph == 4);
        chk("timeout", timeout, to);
        chk("ld_ovf", ld_ovf, ovf);
`ifdef BETA_BOOT_CYCLE_CNT_EN
        chk("run_cycles", run_cycles, rc > 65535 ? 65535 : rc);
`endif
      end
      if (!RESET_N) begin
        ph = 0; to = 0; ovf = 0; rc = 0;
      end else if (ph >= 0) begin
        case (ph)
          0, 4: if (start) begin
            ph = 1; ip = 0; dp = 0; to = 0; ovf = 0; rc = 0;
          end
          1: if (ld_valid) begin
            if (!ld_sel) begin
              if (ip < IDEP) ip++;
              else ovf = 1;
            end else begin
              if (dp < DDEP) dp++;
              else ovf = 1;
            end
            if (ld_last) begin
              ph = 2;
              pcs.delete();
            end
          end
          2: begin
            rc++;
            pcs.push_back(cpu_pc);
            halted = pcs.size() > HS;
            for (int i = 1; i <= HS && halted; i++)
              if (pcs[pcs.size() - 1 - i] != cpu_pc) halted = 0;
            if (halted || rc == TO) begin
              ph = 3; ri = 0; to = !halted;
            end
          end
          3: begin
            if (ri == RB_WORDS) ph = 4;
            ri++;
          end
          default: ;
        endcase
      end
    end
  end

  // event tallies for the hand-computed scenario expectations
  initial forever begin
    @(negedge clk);
    if (imem_we) begin
      if (imem_addr != n_iw) ia_bad++;
      n_iw++;
    end
    if (dmem_we) begin
      if (dmem_addr != n_dw) da_bad++;
      n_dw++;
    end
    if (b_dmem_we) begin
      if (b_dmem_addr != n_bw) ba_bad++;
      n_bw++;
    end
    if (!cpu_reset) n_run++;
    if (rb_valid) begin
      if (rb_idx < 2) rb_seen[rb_idx] = rb_data;
      n_rb++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_iw = 0; n_dw = 0; n_bw = 0; n_run = 0; n_rb = 0; ia_bad = 0; da_bad = 0; ba_bad = 0;
    rb_seen[0] = '0; rb_seen[1] = '0;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic load_word(input bit sel, input logic [127:0] d, input bit last, input bit st = 0);
    ld_valid = 1; ld_sel = sel; ld_data = d; ld_last = last; start = st;
    tick();
    ld_valid = 0; ld_last = 0; start = 0; ld_data = '0;
  endtask

  task automatic wait_done(input string name, input int lim);
    int n;
    n = 0;
    while (!done && n < lim) begin
      tick();
      n++;
    end
    chk(name, done, 1);
  endtask

  task automatic run_halt();
    clr();
    stop_pc = 32'd44;
    store_en = 1;
    pulse_start();
    for (int i = 0; i < 12; i++) load_word(0, iword(i), 0, i == 5);
    for (int i = 0; i < 5; i++) load_word(1, dword(i), i == 4);
    wait_done("halt done reached", 200);
    chk("halt imem writes", n_iw, 12);
    chk("halt imem addr order", ia_bad, 0);
    chk("halt dmem writes", n_dw, 5);
    chk("halt dmem addr order", da_bad, 0);
    chk("halt run cycles", n_run, 16);
    chk("halt rb count", n_rb, 2);
    chk("halt rb_data0", rb_seen[0], dword(0));
    chk("halt rb_data1", rb_seen[1], 128'd55);
    chk("halt timeout", timeout, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    foreach (bmem[i]) bmem[i] = '0;
    stop_pc = 32'hFFFF_FFFF;
    store_en = 0;
    clr();
    repeat (3) tick();
    RESET_N = 1;
    @(negedge clk);
    chk("reset cpu_reset", cpu_reset, 1);
    chk("reset done", done, 0);
    chk("reset ld_ready", ld_ready, 0);
    chk("reset timeout", timeout, 0);
    chk("reset ld_ovf", ld_ovf, 0);
    chk("reset rb_valid", rb_valid, 0);
    tick();
    load_word(0, iword(99), 1);
    chk("idle load ignored", n_iw, 0);

    run_halt();

    // timeout run with dmem overflow, entered by start from DONE
    clr();
    stop_pc = 32'hFFFF_FFFF;
    store_en = 0;
    pulse_start();
    @(negedge clk);
    chk("restart done cleared", done, 0);
    tick();
    for (int i = 0; i < 3; i++) load_word(0, iword(i), 0);
    for (int i = 0; i < 17; i++) load_word(1, dword(i), i == 16);
    wait_done("timeout done reached", 300);
    chk("timeout run cycles", n_run, 64);
    chk("timeout flag", timeout, 1);
    chk("timeout ld_ovf", ld_ovf, 1);
    chk("timeout dmem writes", n_dw, 16);
    chk("timeout rb count", n_rb, 2);
    chk("timeout rb_data1", rb_seen[1], dword(1));
`ifdef BETA_BOOT_CYCLE_CNT_EN
    chk("timeout run_cycles", run_cycles, 64);
`endif

    // halt lands on the timeout cycle; small dmem drops its last two words
    clr();
    stop_pc = 32'd236;
    pulse_start();
    @(negedge clk);
    chk("restart timeout cleared", timeout, 0);
    chk("restart ld_ovf cleared", ld_ovf, 0);
    tick();
    load_word(0, iword(0), 0);
    for (int i = 0; i < 6; i++) load_word(1, dword(i), i == 5);
    wait_done("tie done reached", 300);
    chk("tie run cycles", n_run, 64);
    chk("tie timeout", timeout, 0);
    chk("tie ld_ovf", ld_ovf, 0);
    chk("tie dmem writes", n_dw, 6);
    chk("small dmem writes", n_bw, 4);
    chk("small dmem addr order", ba_bad, 0);
    chk("small ld_ovf", b_ld_ovf, 1);

    // reset in the middle of RUN, then a clean reload
    clr();
    stop_pc = 32'd44;
    store_en = 1;
    pulse_start();
    load_word(0, iword(0), 0);
    load_word(0, iword(1), 0);
    load_word(1, dword(0), 1);
    repeat (5) tick();
    chk("midrun running", cpu_reset, 0);
    RESET_N = 0;
    tick();
    RESET_N = 1;
    @(negedge clk);
    chk("midrun reset cpu_reset", cpu_reset, 1);
    chk("midrun reset done", done, 0);
    chk("midrun reset ld_ready", ld_ready, 0);
    tick();
    run_halt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
